cr_fifo_rd_pipe: RTL

CR_FIFO_RD_PIPE -- requirements
Module: cr_fifo_rd_pipe

---
 rtl/cr_fifo_rd_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/cr_fifo_rd_pipe.sv
// Two-entry skid buffer that pops a source FIFO and presents beats on a
// valid/ready output, counting every accepted beat.
module cr_fifo_rd_pipe #(
    parameter int N_DATA_BITS = 64,
    parameter int N_CNT_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   fifo_empty,
    input  logic [N_DATA_BITS-1:0] fifo_rdata,
    output logic                   fifo_ren,
    output logic                   out_valid,
    output logic [N_DATA_BITS-1:0] out_data,
    input  logic                   out_ready,
    output logic [1:0]             occ,
    output logic [N_CNT_BITS-1:0]  xfer_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N_DATA_BITS-1:0] head_q, head_d;
    logic [N_DATA_BITS-1:0] tail_q, tail_d;
    logic [N_CNT_BITS-1:0]  cnt_q;
    logic                   run_q;
    logic                   push;
    logic                   pop;

    // run_q holds off the first pop until one edge after reset release, so the
    // source never sees a pop strobe while reset is asserted or being released.
    assign fifo_ren  = run_q & ~fifo_empty & (state_q != ST_TWO) & ~clear;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign occ       = state_q;
    assign xfer_cnt  = cnt_q;

    assign push = fifo_ren;
    assign pop  = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        head_d  = fifo_rdata;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d = ST_TWO;
                        tail_d  = fifo_rdata;
                    end else if (pop && !push) begin
                        state_d = ST_EMPTY;
                    end else if (push && pop) begin
                        head_d  = fifo_rdata;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            run_q   <= 1'b1;
            // A pop coinciding with clear is dropped, not counted.
            if (clear) begin
                cnt_q <= '0;
            end else if (pop) begin
                cnt_q <= cnt_q + {{(N_CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
